// File: rtl/rv_pkg.sv
// Shared RV32 front-end types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  // addi x0, x0, 0 -- presented to decode whenever nothing valid is buffered
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch result: the word and the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and empty/full flags.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full (without a pop) and pop while empty are ignored; flush wins over both.
module sync_fifo
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop against occupancy and compute next pointers and count
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only read while the count says they are live
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues imem word requests, buffers {pc, inst} pairs for decode.
// Latency: grant at t with response at t+k gives o_inst_valid at t+k+1; one instruction/cycle sustained.
// Backpressure: a request is raised only while outstanding + buffered < FIFO_DEPTH (registered terms), so the buffer never overflows.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst_data,
  output logic [XLEN-1:0]   o_inst_pc,
  input  logic              i_inst_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   ibuf_cnt, addr_cnt;
  logic [CW:0]     credit_sum;
  logic            ibuf_empty, ibuf_full, addr_empty, addr_full;
  logic [XLEN-1:0] rsp_pc;
  fetch_entry_t    ibuf_wdata, ibuf_head;
  logic            fire, rsp, ibuf_push, ibuf_pop;
  logic            unused_fifo_status;

  // Credit check uses registered counts only, so a same-cycle pop does not free a slot
  assign credit_sum  = {1'b0, outst_q} + {1'b0, ibuf_cnt};
  assign o_imem_req  = (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign o_imem_addr = pc_q;

  assign fire = o_imem_req && i_imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp  = i_imem_rvalid && (outst_q != '0);

  assign ibuf_push  = rsp && (kill_q == '0) && !i_redirect;
  assign ibuf_pop   = !ibuf_empty && i_inst_ready && !i_redirect;
  assign ibuf_wdata = '{pc: rsp_pc, inst: i_imem_rdata};

  // Next PC, outstanding count and discard count
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CW'(fire) - CW'(rsp);
    kill_d  = kill_q;
    if (i_redirect) begin
      pc_d   = i_redirect_pc;
      // outst already includes responses marked for discard, so after a redirect
      // everything still in flight (incl. a grant taken this cycle) is to be dropped
      kill_d = outst_d;
    end else begin
      if (fire) pc_d = pc_q + 32'd4;
      if (rsp && (kill_q != '0)) kill_d = kill_q - 1'b1;
    end
  end

  // Fetch state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      kill_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      kill_q  <= kill_d;
    end
  end

  // PC of every granted request, popped in order as responses return
  sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .flush_i (1'b0),
    .push_i  (fire),
    .pop_i   (rsp),
    .wdata_i (pc_q),
    .rdata_o (rsp_pc),
    .count_o (addr_cnt),
    .empty_o (addr_empty),
    .full_o  (addr_full)
  );

  // Returned instructions awaiting decode; a redirect empties it
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .flush_i (i_redirect),
    .push_i  (ibuf_push),
    .pop_i   (ibuf_pop),
    .wdata_i (ibuf_wdata),
    .rdata_o (ibuf_head),
    .count_o (ibuf_cnt),
    .empty_o (ibuf_empty),
    .full_o  (ibuf_full)
  );

  // Address-queue occupancy mirrors outst_q and the credit rule keeps both FIFOs from overfilling
  assign unused_fifo_status = ^{addr_empty, addr_full, ibuf_full, addr_cnt};

  assign o_inst_valid = !ibuf_empty;
  assign o_inst_data  = ibuf_empty ? NOP_INST : ibuf_head.inst;
  assign o_inst_pc    = ibuf_empty ? '0 : ibuf_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import rv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic [31:0] o_inst_data;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_inst_valid  (o_inst_valid),
    .o_inst_data   (o_inst_data),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  int           errors = 0;
  int           checks = 0;
  int           cyc    = 0;
  int           lat    = 1;
  int           n_pops = 0;
  logic [31:0]  first_pc;
  logic [31:0]  m_pc;
  logic [31:0]  stall_addr;
  mreq_t        mq[$];
  fetch_entry_t sb[$];
  vec_t         vt[11];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: memory reply, output checks, scoreboard update, then advance to the next falling edge
  task automatic step();
    fetch_entry_t e;
    mreq_t        m;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      m             = mq.pop_front();
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = memf(m.addr);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end
    chk("imem_addr", o_imem_addr, m_pc);
    if (!o_inst_valid) begin
      chk("idle_data", o_inst_data, NOP_INST);
      chk("idle_pc", o_inst_pc, 32'h0);
    end else if (i_inst_ready && !i_redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst (cycle %0d): got pc %h, expected no instruction", cyc, o_inst_pc);
      end else begin
        e = sb.pop_front();
        chk("inst_pc", o_inst_pc, e.pc);
        chk("inst_data", o_inst_data, e.inst);
      end
      if (n_pops == 0) first_pc = o_inst_pc;
      n_pops++;
    end
    if (o_imem_req && i_imem_gnt) begin
      mq.push_back('{addr: o_imem_addr, due: cyc + lat});
      sb.push_back('{pc: m_pc, inst: memf(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    if (i_redirect) begin
      sb.delete();
      m_pc = i_redirect_pc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_model();
    mq.delete();
    sb.delete();
    m_pc          = RESET_PC;
    cyc           = 0;
    n_pops        = 0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    i_rst_n       = 1'b0;
    i_imem_gnt    = 1'b0;
    i_inst_ready  = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    clear_model();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // Stop granting and let everything still expected come out
  task automatic drain(input string name);
    i_imem_gnt   = 1'b0;
    i_inst_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || mq.size() != 0); i++) step();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Backpressure sequence, lat=1, ready held low for cycles 0..5
    vt[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    vt[10] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    // Reset values while reset is held
    i_rst_n = 1'b0;
    i_imem_gnt = 1'b0; i_inst_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    clear_model();
    #12;
    chk("rst_req", o_imem_req, 1'b1);
    chk("rst_addr", o_imem_addr, RESET_PC);
    chk("rst_valid", o_inst_valid, 1'b0);
    chk("rst_data", o_inst_data, NOP_INST);
    chk("rst_pc", o_inst_pc, 32'h0);

    // Streaming with 1-cycle memory and decode always ready
    do_reset();
    lat = 1; i_imem_gnt = 1'b1; i_inst_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c >= 2) chk("stream_valid", o_inst_valid, 1'b1);
      step();
    end
    chk("stream_pops", n_pops, 18);
    chk("stream_first_pc", first_pc, RESET_PC);
    drain("stream_drain");

    // Backpressure table
    do_reset();
    lat = 1;
    for (int i = 0; i < 11; i++) begin
      i_imem_gnt   = vt[i].gnt;
      i_inst_ready = vt[i].rdy;
      chk($sformatf("bp_req[%0d]", i), o_imem_req, vt[i].req);
      chk($sformatf("bp_addr[%0d]", i), o_imem_addr, vt[i].addr);
      chk($sformatf("bp_vld[%0d]", i), o_inst_valid, vt[i].vld);
      chk($sformatf("bp_pc[%0d]", i), o_inst_pc, vt[i].pc);
      step();
    end
    drain("bp_drain");

    // Redirect with two requests in flight (3-cycle memory)
    do_reset();
    lat = 3; i_inst_ready = 1'b1; i_imem_gnt = 1'b1;
    step();
    step();
    i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h100;
    step();
    i_redirect = 1'b0; i_imem_gnt = 1'b1;
    chk("rd2_addr", o_imem_addr, 32'h100);
    chk("rd2_valid", o_inst_valid, 1'b0);
    n_pops = 0;
    for (int c = 0; c < 12; c++) step();
    chk("rd2_first_pc", first_pc, 32'h100);
    chk("rd2_popped", (n_pops > 0), 1'b1);
    drain("rd2_drain");

    // Redirect coinciding with a response and a new grant
    do_reset();
    lat = 1; i_inst_ready = 1'b1; i_imem_gnt = 1'b1;
    for (int c = 0; c < 6; c++) step();
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    step();
    i_redirect = 1'b0;
    chk("rdc_valid_t1", o_inst_valid, 1'b0);
    chk("rdc_addr_t1", o_imem_addr, 32'h200);
    step();
    chk("rdc_valid_t2", o_inst_valid, 1'b0);
    step();
    chk("rdc_valid_t3", o_inst_valid, 1'b1);
    chk("rdc_pc_t3", o_inst_pc, 32'h200);
    for (int c = 0; c < 6; c++) step();

    // Grant stall: request held with a stable address, PC moves only on the grant
    i_imem_gnt = 1'b0;
    stall_addr = m_pc;
    for (int c = 0; c < 5; c++) begin
      chk("stall_req", o_imem_req, 1'b1);
      chk("stall_addr", o_imem_addr, stall_addr);
      step();
    end
    i_imem_gnt = 1'b1;
    chk("stall_grant_addr", o_imem_addr, stall_addr);
    step();
    chk("stall_next_addr", o_imem_addr, stall_addr + 32'd4);
    drain("stall_drain");

    // Reset asserted mid-stream with outstanding and buffered work
    do_reset();
    lat = 3; i_inst_ready = 1'b0; i_imem_gnt = 1'b1;
    for (int c = 0; c < 5; c++) step();
    chk("mid_pre_valid", o_inst_valid, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_req", o_imem_req, 1'b1);
    chk("mid_rst_addr", o_imem_addr, RESET_PC);
    chk("mid_rst_valid", o_inst_valid, 1'b0);
    chk("mid_rst_data", o_inst_data, NOP_INST);
    chk("mid_rst_pc", o_inst_pc, 32'h0);
    i_imem_gnt = 1'b0; i_inst_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    lat = 1; i_imem_gnt = 1'b1; i_inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("mid_restart_pc", first_pc, RESET_PC);
    chk("mid_restart_pops", n_pops, 6);
    drain("mid_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
